// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared 1-bit full-adder cell stepped
// LSB-first with a registered carry, trading latency for area.

module oneBit_full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;

  oneBit_full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Next result value: shift right, new sum bit enters at the MSB.
  // Written with shifts so WIDTH=1 needs no special-case slicing.
  always_comb begin
    res_next = (res >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // Controller FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr    <= a_in;
            b_sr    <= b_in;
            carry_q <= cin;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res     <= res_next;
          carry_q <= fa_carry;
          cnt     <= cnt + CW'(1);
          if (last_bit) begin
            sum_out <= res_next;
            cout    <= fa_carry;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

- Bit-serial N-bit adder controller built around the team's `oneBit_full_adder` cell, one instance.
- Accepts two WIDTH-bit operands and a carry-in on a start pulse, then steps the 1-bit cell LSB-first over WIDTH cycles with a registered carry.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Sits between a requester that needs wide additions and the shared 1-bit adder datapath, trading latency for area.

## Interface

- `WIDTH`, default 8, operand/result width in bits; legal range ≥ 1.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `a_in` input WIDTH: operand A, captured on accepted start.
- `b_in` input WIDTH: operand B, captured on accepted start.
- `cin` input 1: carry-in, captured on accepted start.
- `busy` output 1: high while in RUN or DONE.
- `done` output 1: one-cycle pulse when the result becomes valid.
- `sum_out` output WIDTH: registered result; holds the last completed sum.
- `cout` output 1: registered final carry; holds with `sum_out`.

## Operation

- Internal state: A/B shift registers (WIDTH), carry flop, result shift register (WIDTH), bit counter (`$clog2(WIDTH+1)` bits), FSM.
- States:
  - IDLE: `start=1` loads `a_in`/`b_in` into the shift registers, `cin` into the carry flop and 0 into the counter, then goes to RUN. `start=0` stays in IDLE.
  - RUN: the 1-bit cell takes `a=A[0]`, `b=B[0]`, `c=carry`. Each edge shifts A and B right by one, shifts the cell `sum` into the result MSB (result shifts right), loads the cell `carry` into the carry flop and increments the counter. When the counter reaches WIDTH-1 on this edge (last bit), go to DONE.
  - DONE: the edge entering DONE also copies the result register to `sum_out` and the carry flop to `cout`. `done=1` for this one cycle, then unconditionally go to IDLE.
- `start` is ignored in RUN and DONE. There is no queuing, and dropped requests are not flagged.
- Operand inputs are only sampled at the accepting edge. Changing them mid-operation has no effect.
- `sum_out`/`cout` change only on the transition into DONE. They stay stable during a new computation until it completes.
- Arithmetic: {cout, sum_out} = a_in + b_in + cin, exact modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing

- Reset values (async, immediate): state IDLE; `busy=0`, `done=0`, `sum_out=0`, `cout=0`; all internal registers 0.
- Accepting edge E (start=1 in IDLE): `busy=1` from E. Bits are processed at edges E+1 … E+WIDTH. State is DONE and `done=1` from edge E+WIDTH through E+WIDTH+1.
- Latency is start-edge to done-high = WIDTH cycles. Back at IDLE with `busy=0` after edge E+WIDTH+1.
- Earliest next accept is edge E+WIDTH+2, giving a throughput of one addition per WIDTH+2 cycles.
- `done` and `busy` are registered, FSM-decoded outputs with no combinational path from inputs.
- `rst` mid-RUN or mid-DONE: the operation is abandoned immediately. Outputs go to reset values, with `sum_out`/`cout` cleared and no `done` pulse. The first accept is possible at the first edge after `rst` deasserts.
- `start` held high continuously: one operation per WIDTH+2 cycles, each accepted on an IDLE edge.

## Test plan

- Reset then 0x00+0x00, cin=0, WIDTH=8: `busy` rises at the accept edge, `done` pulses exactly 8 cycles later, sum_out=0x00, cout=0, and `busy` falls one cycle after `done`.
- Carry ripple: 0xFF+0x01, cin=0 gives sum_out=0x00, cout=1. Then 0xA5+0x5A, cin=1 gives sum_out=0x00, cout=1. Then 0x12+0x34, cin=0 gives sum_out=0x46, cout=0.
- Hold and ignore:
  - After 0x0F+0x01 (result 0x10), start 0x80+0x80 and pulse `start` with different operands during RUN.
  - `sum_out` must stay 0x10 until the next `done`, then read 0x00 with cout=1.
  - Exactly one `done` pulse occurs.
- Reset mid-operation: assert `rst` at RUN bit 4 for one cycle. Outputs are 0 immediately and no `done` follows. A new 0x03+0x04 start then yields 0x07 after 8 cycles.
- Exhaustive with WIDTH=4: all 512 (a, b, cin) combinations with `start` held high. Each `done` must match {cout, sum_out} = a+b+cin, with accepts spaced 6 cycles apart.
- WIDTH=1 corner: 1+1, cin=1 gives sum_out=1, cout=1, and `done` one cycle after the accept edge.
